// File: rtl/mem_port_arbiter_if.sv
// Requester beat/response signals and the native RAM port shared through mem_port_arbiter.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          mem_w_en;
  logic [ADDR_WIDTH-1:0]         mem_w_addr;
  logic [DATA_WIDTH-1:0]         mem_w_data;
  logic                          mem_r_en;
  logic [ADDR_WIDTH-1:0]         mem_r_addr;
  logic [DATA_WIDTH-1:0]         mem_r_data;

  modport slave (
    input  req_valid, req_we, req_last, req_addr, req_wdata, mem_r_data,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
  );

  modport master (
    output req_valid, req_we, req_last, req_addr, req_wdata, mem_r_data,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Burst-locked round-robin arbiter sharing one native RAM port between NUM_REQ requesters.
// Define MEM_ARB_FIXED_PRIO_EN to select the lowest-index valid requester instead of round-robin.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               ACLK,
  input  logic               ARESET,
  mem_port_arbiter_if.slave  bus,
  output logic [IDW-1:0]     grant_id
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic           pick_found;
  logic [IDW-1:0] pick_id;
  int             pick_idx;
  logic           fire, fire_we, fire_last;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;

  logic [RD_LATENCY-1:0] rd_vld_q;
  logic [IDW-1:0]        rd_id_q [RD_LATENCY];

  // Stage p0: arbitration pick and granted-beat mux (combinational)
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_idx = (int'(rr_q) + i) % NUM_REQ;
      if (!pick_found && bus.req_valid[pick_idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(pick_idx);
      end
    end
  end

  always_comb begin
    g_addr    = bus.req_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    g_wdata   = bus.req_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    fire      = (state_q == BUSY) && bus.req_valid[grant_q];
    fire_we   = fire && bus.req_we[grant_q];
    fire_last = fire && bus.req_last[grant_q];

    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = (state_q == BUSY) && (grant_q == IDW'(i));
    end
    bus.mem_w_en   = fire_we;
    bus.mem_w_addr = fire_we ? g_addr : '0;
    bus.mem_w_data = fire_we ? g_wdata : '0;
    bus.mem_r_en   = fire && !fire_we;
    bus.mem_r_addr = (fire && !fire_we) ? g_addr : '0;

    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (fire_last) begin
          state_d = IDLE;
`ifdef MEM_ARB_FIXED_PRIO_EN
          rr_d = '0;
`else
          rr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Stage p1..pN: read-issue id travels alongside the RAM read latency
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_id_q[i] <= '0;
    end else begin
      rd_vld_q[0] <= fire && !fire_we;
      rd_id_q[0]  <= grant_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_id_q[i]  <= rd_id_q[i-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = rd_vld_q[RD_LATENCY-1] && (rd_id_q[RD_LATENCY-1] == IDW'(i));
    end
    bus.rsp_rdata = rd_vld_q[RD_LATENCY-1] ? bus.mem_r_data : '0;
  end

  assign grant_id = grant_q;

endmodule
